// File: rtl/pipelined_floating_point_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_floating_point_adder
// Brief    : 3-stage IEEE-754 style add/sub, valid/ready, tag, sticky flags.
//            Define FP_ADDER_SUBNORMAL_EN for gradual underflow (else FTZ/DAZ).
// Revision : 1.0
// ============================================================================
module pipelined_floating_point_adder #(
  parameter  int EXPONENT_WIDTH  = 8,
  parameter  int MANTISSA_WIDTH  = 23,
  parameter  int TAG_WIDTH       = 4,
  localparam int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FLOAT_BIT_WIDTH-1:0] a,
  input  logic [FLOAT_BIT_WIDTH-1:0] b,
  input  logic                       subtract,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLOAT_BIT_WIDTH-1:0] out,
  output logic [TAG_WIDTH-1:0]       out_tag,
  output logic                       underflow_flag,
  output logic                       overflow_flag,
  output logic                       invalid_operation_flag,
  input  logic                       clear_sticky,
  output logic [2:0]                 sticky_flags
);
  localparam int FW  = FLOAT_BIT_WIDTH;
  localparam int EW  = EXPONENT_WIDTH;
  localparam int MW  = MANTISSA_WIDTH;
  localparam int EW2 = EW + 2;
  localparam int XW  = MW + 4;            // hidden + fraction + guard/round/sticky
  localparam int SW  = MW + 5;            // XW plus carry
  localparam int LZW = $clog2(XW + 1);
  localparam logic [EW-1:0] SHIFT_LIM = EW'(MW + 3);

  typedef struct packed {
    logic [FW-1:0]        a;
    logic [FW-1:0]        b;
    logic                 sub;
    logic [TAG_WIDTH-1:0] tag;
  } s0_t;

  typedef struct packed {
    logic                 sign;
    logic                 zsign;
    logic                 sub;
    logic [EW-1:0]        exp;
    logic [XW-1:0]        mant_l;
    logic [XW-1:0]        mant_s;
    logic                 spec;
    logic [FW-1:0]        spec_val;
    logic                 inv;
    logic                 ovf;
    logic                 tiny;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic                 sign;
    logic                 zsign;
    logic [EW-1:0]        exp;
    logic [SW-1:0]        sum;
    logic                 spec;
    logic [FW-1:0]        spec_val;
    logic                 inv;
    logic                 ovf;
    logic                 tiny;
    logic [TAG_WIDTH-1:0] tag;
  } s2_t;

  logic                 advance;
  logic                 v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s0_t                  s0_q, s0_d;
  s1_t                  s1_q, s1_d;
  s2_t                  s2_q, s2_d;
  logic [FW-1:0]        out_q, out_d;
  logic [TAG_WIDTH-1:0] tag3_q, tag3_d;
  logic [2:0]           flags_q, flags_d;
  logic [2:0]           sticky_q, sticky_d;

  assign advance = ~v3_q | out_ready;
  assign in_ready = advance;

  // Input capture
  always_comb begin
    v0_d = advance ? in_valid : v0_q;
    s0_d = advance ? {a, b, subtract, in_tag} : s0_q;
  end

  // Stage 1: unpack, classify, swap, align
  logic          a_sign, b_sign, a_ge, l_sign, tiny_in;
  logic [EW-1:0] a_exp, b_exp, a_e, b_e, l_e, s_e, shift;
  logic [MW-1:0] a_frac, b_frac;
  logic [MW:0]   a_m, b_m, l_m, s_m;
  logic [XW-1:0] ext, lost, aligned;
  logic          a_nan, b_nan, a_inf, b_inf;

  assign a_sign = s0_q.a[FW-1];
  assign b_sign = s0_q.b[FW-1] ^ s0_q.sub;
  assign a_exp  = s0_q.a[FW-2:MW];
  assign b_exp  = s0_q.b[FW-2:MW];
  assign a_frac = s0_q.a[MW-1:0];
  assign b_frac = s0_q.b[MW-1:0];
  assign a_nan  = (&a_exp) & (|a_frac);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign a_inf  = (&a_exp) & ~(|a_frac);
  assign b_inf  = (&b_exp) & ~(|b_frac);

  always_comb begin
`ifdef FP_ADDER_SUBNORMAL_EN
    a_e     = (a_exp == '0) ? EW'(1) : a_exp;
    b_e     = (b_exp == '0) ? EW'(1) : b_exp;
    a_m     = {a_exp != '0, a_frac};
    b_m     = {b_exp != '0, b_frac};
    tiny_in = 1'b0;
`else
    a_e     = a_exp;
    b_e     = b_exp;
    a_m     = (a_exp == '0) ? '0 : {1'b1, a_frac};
    b_m     = (b_exp == '0) ? '0 : {1'b1, b_frac};
    // Both operands flushed, yet their true sum would have been nonzero
    tiny_in = (a_exp == '0) && (b_exp == '0) && ((a_frac | b_frac) != '0) &&
              !((a_frac == b_frac) && (a_sign != b_sign));
`endif
    a_ge    = {a_e, a_m} >= {b_e, b_m};
    l_e     = a_ge ? a_e : b_e;
    s_e     = a_ge ? b_e : a_e;
    l_m     = a_ge ? a_m : b_m;
    s_m     = a_ge ? b_m : a_m;
    l_sign  = a_ge ? a_sign : b_sign;
    shift   = l_e - s_e;
    ext     = {s_m, 3'b000};
    lost    = ext & ~({XW{1'b1}} << shift);
    aligned = (shift >= SHIFT_LIM) ? {{(XW-1){1'b0}}, |ext}
                                   : ((ext >> shift) | {{(XW-1){1'b0}}, |lost});

    v1_d = advance ? v0_q : v1_q;
    s1_d = s1_q;
    if (advance) begin
      s1_d.sign     = l_sign;
      s1_d.zsign    = a_sign & b_sign;
      s1_d.sub      = a_sign ^ b_sign;
      s1_d.exp      = l_e;
      s1_d.mant_l   = {l_m, 3'b000};
      s1_d.mant_s   = aligned;
      s1_d.spec     = 1'b0;
      s1_d.spec_val = '0;
      s1_d.inv      = 1'b0;
      s1_d.ovf      = 1'b0;
      s1_d.tiny     = tiny_in;
      s1_d.tag      = s0_q.tag;
      if (a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign))) begin
        s1_d.spec     = 1'b1;
        s1_d.spec_val = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        s1_d.inv      = 1'b1;
      end else if (a_inf | b_inf) begin
        s1_d.spec     = 1'b1;
        s1_d.spec_val = {a_inf ? a_sign : b_sign, {EW{1'b1}}, {MW{1'b0}}};
        s1_d.ovf      = 1'b1;
      end
    end
  end

  // Stage 2: magnitude add/subtract (mant_l >= mant_s by construction)
  always_comb begin
    v2_d = advance ? v1_q : v2_q;
    s2_d = s2_q;
    if (advance) begin
      s2_d.sign     = s1_q.sign;
      s2_d.zsign    = s1_q.zsign;
      s2_d.exp      = s1_q.exp;
      s2_d.sum      = s1_q.sub ? ({1'b0, s1_q.mant_l} - {1'b0, s1_q.mant_s})
                               : ({1'b0, s1_q.mant_l} + {1'b0, s1_q.mant_s});
      s2_d.spec     = s1_q.spec;
      s2_d.spec_val = s1_q.spec_val;
      s2_d.inv      = s1_q.inv;
      s2_d.ovf      = s1_q.ovf;
      s2_d.tiny     = s1_q.tiny;
      s2_d.tag      = s1_q.tag;
    end
  end

  // Stage 3: normalise, round to nearest even, pack
  logic [LZW-1:0]    lz;
  logic [EW2-1:0]    ext_exp, e_n, res_exp;
  logic [XW-1:0]     norm;
  logic              flush, is_zero, round_up, inexact;
  logic [EW2+MW-1:0] packed_r;
  logic [FW-1:0]     res;
  logic [2:0]        res_flags;
  logic              hs;

  always_comb begin
    lz = LZW'(XW);
    for (int i = 0; i < XW; i++) begin
      if (s2_q.sum[i]) lz = LZW'(XW - 1 - i);
    end
    ext_exp = {2'b00, s2_q.exp};
    is_zero = ~(|s2_q.sum);
    norm    = '0;
    e_n     = '0;
    flush   = 1'b0;
    if (s2_q.sum[SW-1]) begin
      norm = {s2_q.sum[SW-1:2], |s2_q.sum[1:0]};
      e_n  = ext_exp + EW2'(1);
    end else if (ext_exp > EW2'(lz)) begin
      norm = s2_q.sum[XW-1:0] << lz;
      e_n  = ext_exp - EW2'(lz);
    end else begin
`ifdef FP_ADDER_SUBNORMAL_EN
      norm = s2_q.sum[XW-1:0] << (s2_q.exp - EW'(1));
      e_n  = '0;
`else
      flush = 1'b1;
`endif
    end
    inexact  = |norm[2:0];
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    // A mantissa carry from rounding propagates straight into the exponent
    packed_r = {e_n, norm[XW-2:3]} + {{(EW2+MW-1){1'b0}}, round_up};
    res_exp  = packed_r[EW2+MW-1:MW];

    res       = {s2_q.sign, packed_r[EW+MW-1:0]};
    res_flags = {2'b00, (res_exp == '0) & inexact};
    if (s2_q.spec) begin
      res       = s2_q.spec_val;
      res_flags = {s2_q.inv, s2_q.ovf, 1'b0};
    end else if (is_zero) begin
      res       = {s2_q.zsign, {(FW-1){1'b0}}};
      res_flags = {2'b00, s2_q.tiny};
    end else if (flush) begin
      res       = {s2_q.sign, {(FW-1){1'b0}}};
      res_flags = 3'b001;
    end else if (res_exp >= {2'b00, {EW{1'b1}}}) begin
      res       = {s2_q.sign, {EW{1'b1}}, {MW{1'b0}}};
      res_flags = 3'b010;
    end

    v3_d    = advance ? v2_q : v3_q;
    out_d   = advance ? res : out_q;
    tag3_d  = advance ? s2_q.tag : tag3_q;
    flags_d = advance ? res_flags : flags_q;

    hs       = v3_q & out_ready;
    sticky_d = sticky_q;
    if (clear_sticky) sticky_d = hs ? flags_q : 3'b000;
    else if (hs)      sticky_d = sticky_q | flags_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_q    <= '0;
      tag3_q   <= '0;
      flags_q  <= '0;
      sticky_q <= '0;
    end else begin
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      out_q    <= out_d;
      tag3_q   <= tag3_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid              = v3_q;
  assign out                    = out_q;
  assign out_tag                = tag3_q;
  assign invalid_operation_flag = flags_q[2];
  assign overflow_flag          = flags_q[1];
  assign underflow_flag         = flags_q[0];
  assign sticky_flags           = sticky_q;

endmodule
`default_nettype wire
